// File: rtl/ones_run_generator_if.sv
// Run-request channel for ones_run_generator: valid/ready handshake carrying
// the ones count and trailing-gap length of one run.
interface ones_run_generator_if #(
    parameter int LEN_W = 4,
    parameter int GAP_W = 4
);
    // Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
    // the payload is sampled only on that edge and the source may change it freely afterwards.
    logic             req_valid;
    logic             req_ready;
    logic [LEN_W-1:0] req_ones;
    logic [GAP_W-1:0] req_gap;

    modport master (output req_valid, output req_ones, output req_gap, input req_ready);
    modport slave  (input req_valid, input req_ones, input req_gap, output req_ready);
endinterface

// File: rtl/ones_run_generator.sv
// Serial run generator: per accepted request emits req_ones 1s then req_gap 0s on c.
// Optional EXPECT_FLAG_EN adds expect_d, the expected overlapping detector output.
module ones_run_generator #(
    parameter int LEN_W = 4,
    parameter int GAP_W = 4,
    parameter int DET_N = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    ones_run_generator_if.slave  req,
    output logic                 c,
    output logic                 busy,
    output logic                 done,
`ifdef EXPECT_FLAG_EN
    output logic                 expect_d,
`endif
    output logic [1:0]           dbg_state_o
);
    localparam int CNT_W = (LEN_W > GAP_W) ? LEN_W : GAP_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONES = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               c_q, busy_q, done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req.req_valid) begin
                    gap_d = req.req_gap;
                    if (req.req_ones != '0) begin
                        state_d = ONES;
                        cnt_d   = CNT_W'(req.req_ones) - CNT_W'(1);
                    end else if (req.req_gap != '0) begin
                        state_d = GAP;
                        cnt_d   = CNT_W'(req.req_gap) - CNT_W'(1);
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ONES: begin
                if (cnt_q == '0) begin
                    if (gap_q != '0) begin
                        state_d = GAP;
                        cnt_d   = CNT_W'(gap_q) - CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so c follows the accept edge by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            c_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            c_q     <= (state_d == ONES);
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
        end
    end

`ifdef EXPECT_FLAG_EN
    localparam logic [LEN_W:0] DET_K = (LEN_W+1)'(DET_N);

    logic [LEN_W:0] run_k_q, run_k_d;
    logic           expect_q;

    // run_k is the 1-based index of the bit about to appear on c within its run.
    always_comb begin
        run_k_d = '0;
        if (state_d == ONES) begin
            run_k_d = run_k_q + (LEN_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_k_q  <= '0;
            expect_q <= 1'b0;
        end else begin
            run_k_q  <= run_k_d;
            expect_q <= (state_d == ONES) && (run_k_d >= DET_K);
        end
    end

    assign expect_d = expect_q;
`endif

    assign req.req_ready = (state_q == IDLE);
    assign c             = c_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_ones_run_generator.sv
// Directed and randomized bench for ones_run_generator; expected waveforms are
// derived from each request's (ones, gap) values rather than from the FSM.
module tb_ones_run_generator;
    localparam int LEN_W = 4;
    localparam int GAP_W = 4;
    localparam int DET_N = 3;

    logic       clk;
    logic       reset;
    logic       c, busy, done;
    logic [1:0] dbg_state;
    logic       expect_w;

    int n_checks = 0;
    int n_fail   = 0;

    ones_run_generator_if #(.LEN_W(LEN_W), .GAP_W(GAP_W)) rif ();

    ones_run_generator #(.LEN_W(LEN_W), .GAP_W(GAP_W), .DET_N(DET_N)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (rif.slave),
        .c          (c),
        .busy       (busy),
        .done       (done),
`ifdef EXPECT_FLAG_EN
        .expect_d   (expect_w),
`endif
        .dbg_state_o(dbg_state)
    );

`ifndef EXPECT_FLAG_EN
    assign expect_w = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, " c"}, 32'(c), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'(exp_done));
        chk({tag, " ready"}, 32'(rif.req_ready), 32'd1);
        chk({tag, " state"}, 32'(dbg_state), 32'd0);
    endtask

    // Cycle i (1-based after accept): ones occupy 1..n, zeros n+1..n+g, then one IDLE cycle with done.
    task automatic check_span(input int n, input int g, input int first, input int last);
        int total;
        logic e_c, e_busy, e_done, e_ready, e_exp;
        total = n + g + 1;
        for (int i = first; i <= last; i++) begin
            @(negedge clk);
            e_c     = (i <= n);
            e_busy  = (i <= n + g);
            e_done  = (i == total);
            e_ready = (i == total);
            e_exp   = (i <= n) && (i >= DET_N);
            chk($sformatf("run(%0d,%0d)#%0d c", n, g, i), 32'(c), 32'(e_c));
            chk($sformatf("run(%0d,%0d)#%0d busy", n, g, i), 32'(busy), 32'(e_busy));
            chk($sformatf("run(%0d,%0d)#%0d done", n, g, i), 32'(done), 32'(e_done));
            chk($sformatf("run(%0d,%0d)#%0d ready", n, g, i), 32'(rif.req_ready), 32'(e_ready));
`ifdef EXPECT_FLAG_EN
            chk($sformatf("run(%0d,%0d)#%0d expect_d", n, g, i), 32'(expect_w), 32'(e_exp));
`endif
        end
    endtask

    // Called near a negedge while the DUT is idle; hold keeps valid high with scrambled payload.
    task automatic accept(input int n, input int g, input bit hold);
        rif.req_valid = 1'b1;
        rif.req_ones  = LEN_W'(n);
        rif.req_gap   = GAP_W'(g);
        @(posedge clk);
        #1;
        if (hold) begin
            rif.req_ones = LEN_W'($urandom_range(0, 15));
            rif.req_gap  = GAP_W'($urandom_range(0, 15));
        end else begin
            rif.req_valid = 1'b0;
        end
    endtask

    task automatic issue(input int n, input int g, input bit hold);
        accept(n, g, hold);
        check_span(n, g, 1, n + g + 1);
    endtask

    initial begin
        int n, g;
        bit hold;
        reset         = 1'b1;
        rif.req_valid = 1'b0;
        rif.req_ones  = '0;
        rif.req_gap   = '0;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_idle("reset", 1'b0);
        end
        reset = 1'b0;
        @(negedge clk);
        chk_idle("post_reset", 1'b0);

        issue(3, 2, 1'b0);
        issue(15, 0, 1'b0);
        issue(0, 4, 1'b0);
        issue(0, 0, 1'b0);
        @(negedge clk);
        chk_idle("after_zero", 1'b0);

        issue(2, 0, 1'b1);
        issue(4, 1, 1'b0);

        // Reset lands on the edge after the 5th one is on c.
        accept(10, 3, 1'b0);
        check_span(10, 3, 1, 5);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("mid_reset", 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk_idle("mid_reset_release", 1'b0);
        issue(3, 1, 1'b0);

        // Ignored request while busy: valid pulses with a payload that must not be taken.
        accept(5, 2, 1'b0);
        check_span(5, 2, 1, 2);
        rif.req_valid = 1'b1;
        rif.req_ones  = 4'd9;
        rif.req_gap   = 4'd9;
        check_span(5, 2, 3, 4);
        rif.req_valid = 1'b0;
        check_span(5, 2, 5, 8);

        for (int k = 0; k < 25; k++) begin
            n    = $urandom_range(0, 15);
            g    = $urandom_range(0, 15);
            hold = (k != 24) && ($urandom_range(0, 1) == 1);
            issue(n, g, hold);
        end
        @(negedge clk);
        chk_idle("final", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ones_run_generator.md
Name: ones_run_generator

Overview:
- Serial stimulus transmitter, the source side of the consecutive-1s serial link. Its output bit stream feeds consecutive-1s detectors.
- Accepts run requests over a valid/ready handshake. For each request it emits a run of N consecutive 1s, then G 0s, one bit per clock on c.
- Used in subsystem benches and self-test paths to drive consecutive-1s detectors with known patterns.

Parameters:
- LEN_W, 4, width of the run-length (ones count) field
- GAP_W, 4, width of the gap-length (zeros count) field
- DET_N, 3, detector threshold used for the expected-detect flag

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request
- req_ones  input  LEN_W  number of 1 bits to emit (0 allowed)
- req_gap  input  GAP_W  number of trailing 0 bits to emit (0 allowed)
- c  output  1  serial bit stream, registered
- busy  output  1  request in progress (state != IDLE)
- done  output  1  one-cycle pulse when a request completes
- expect_d  output  1  expected Mealy detector output for the current c bit (EXPECT_FLAG_EN only)

Behaviour:
- Clock and reset: one clock domain, clk. reset is synchronous and active-high, sampled on the rising edge.
- Reset values: state=IDLE, c=0, busy=0, done=0, req_ready=1, expect_d=0, all counters 0.
- Reset asserted mid-run: the run is abandoned and the block returns to IDLE on that edge. No done pulse is issued for the abandoned request.
- States:
  - IDLE: c=0, req_ready=1.
  - ONES: c=1, req_ready=0.
  - GAP: c=0, req_ready=0.
- req_ready is 1 only in IDLE. A request is accepted on an edge where req_valid && req_ready.
- Transitions on accept:
  - req_ones!=0: next state ONES; cnt loaded with req_ones-1; gap value latched.
  - req_ones==0 and req_gap!=0: next state GAP; cnt loaded with req_gap-1.
  - both zero: stay IDLE; done=1 on the next cycle; nothing emitted.
- ONES: when cnt==0, go to GAP (cnt=latched_gap-1) if latched_gap!=0, else go to IDLE. Otherwise decrement cnt.
- GAP: when cnt==0, go to IDLE. Otherwise decrement cnt.
- Output timing: c is a registered decode of the state. The first 1 appears on c in the cycle after the accept edge. Latency from accept to first bit = 1 cycle.
- done: registered one-cycle pulse, high in the first IDLE cycle after ONES or GAP completes.
- Back-to-back requests: a request held valid is accepted in that IDLE cycle. The next run therefore starts one cycle later, so every run is followed by at least gap+1 zeros. Runs never merge.
- Run length: req_ones at its maximum (2^LEN_W-1) emits exactly that many 1s. No wrap-around of cnt.
- req_valid outside IDLE is ignored. req_ones and req_gap are sampled only at the accept edge; later changes have no effect.

Optional Feature:
- Macro: EXPECT_FLAG_EN.
- Defined:
  - expect_d is present and registered alongside c.
  - Counter run_k counts the 1-based position of the current 1 within a run; it resets to 0 on every 0 bit.
  - expect_d = c && (run_k >= DET_N), i.e. the overlapping Mealy detector output for the bit currently on c.
  - For a run of N ones, expect_d is high for max(0, N-DET_N+1) cycles.
- Not defined: port expect_d is absent and run_k logic is removed. All other behaviour is identical.

Test Plan:
- Reset check: assert reset for 2 cycles, then release. Required: c=0, busy=0, done=0, req_ready=1 throughout reset and in the first cycle after.
- Basic request: req_ones=3, req_gap=2. Required: c=1,1,1,0,0 starting 1 cycle after accept; done pulses once on the following cycle; with EXPECT_FLAG_EN, expect_d=1 on the 3rd 1 only.
- Long run: req_ones=15, req_gap=0. Required: fifteen consecutive 1s, then IDLE; expect_d high for 13 cycles; no cnt wrap.
- Zero-length fields:
  - req_ones=0, req_gap=4 -> four 0s, busy high for 4 cycles.
  - req_ones=0, req_gap=0 -> busy stays 0, done pulses 1 cycle after accept.
- Back-to-back: req_valid held high with (2,0) then (4,1). Required: c=1,1,0,1,1,1,1,0,0; exactly 2 done pulses; expect_d never high during the 2-run.
- Reset mid-run: accept (10,3), assert reset at the 5th 1. Required: next cycle c=0, state IDLE, no done pulse; a new request is accepted immediately after release.
